// File: rtl/gf_mul_arbiter.sv
// gf_mul_arbiter
// ---------------------------------------------------------------------------
// Purpose:
//   Round-robin arbiter that shares one combinational GF(2^8) multiplier
//   (shift-and-add, field polynomial 0x11D) among NUM_REQ requesters. Each
//   requester presents operands on a valid/ready port. Products return on a
//   single response channel that carries the owner's index and supports
//   backpressure.
//
// Ports:
//   clk        in   1           single clock, rising edge
//   reset      in   1           synchronous, active-high
//   req_valid  in   NUM_REQ     per-requester operand valid
//   req_ready  out  NUM_REQ     per-requester accept (one-hot or zero)
//   req_a      in   8*NUM_REQ   operand A, requester i at [8i+7:8i]
//   req_b      in   8*NUM_REQ   operand B, same packing
//   rsp_valid  out  1           result valid
//   rsp_ready  in   1           downstream accept
//   rsp_data   out  8           A*B mod 0x11D
//   rsp_id     out  ID_W        requester that owns rsp_data
//
// Build option:
//   GF_MUL_ARB_PIPE2_EN  defined   -> stage-1 operand register ahead of the
//                                     multiplier, 2-cycle latency
//                        undefined -> 1-cycle latency
//
// Handshake rules (both request ports and the response port):
//   A transfer happens on a rising clk edge where valid && ready. A source
//   holds valid and its payload stable until accepted. ready may depend
//   combinationally on valid; valid never depends on ready.
// ---------------------------------------------------------------------------
module gf_mul_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_data,
  output logic [ID_W-1:0]        rsp_id
);

  // Shift-and-add multiply; each doubling of x reduces by 0x11D.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  logic [ID_W-1:0] last;      // index of the most recent grant
  logic [ID_W-1:0] win;       // current arbitration winner
  logic            any_valid; // at least one requester is valid
  logic            advance;   // global pipeline enable
  logic            transfer;  // a request handshake completes this cycle
  logic [7:0]      win_a;
  logic [7:0]      win_b;

  assign advance  = !rsp_valid || rsp_ready;
  assign transfer = any_valid && advance && !reset;

  // Search starts one past the last grant and wraps; the first valid wins.
  always_comb begin
    logic [ID_W:0] cand;
    win       = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!any_valid && req_valid[cand[ID_W-1:0]]) begin
        win       = cand[ID_W-1:0];
        any_valid = 1'b1;
      end
    end
  end

  // Only the winner sees ready, and only when the output can take a result.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = transfer && (win == ID_W'(i));
    end
  end

  assign win_a = req_a[8*win +: 8];
  assign win_b = req_b[8*win +: 8];

  // Round-robin pointer: moves only on an actual transfer, so idle and
  // stalled cycles leave the priority order untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= ID_W'(NUM_REQ - 1);
    end else if (transfer) begin
      last <= win;
    end
  end

`ifdef GF_MUL_ARB_PIPE2_EN
  // Stage 1 captures the granted operands; the multiplier sits between
  // stage 1 and the output register. Both stages move together, so a
  // stage-1 bubble is kept rather than squeezed out during a stall.
  logic            s1_valid;
  logic [ID_W-1:0] s1_id;
  logic [7:0]      s1_a;
  logic [7:0]      s1_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_a      <= 8'h00;
      s1_b      <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_id    <= '0;
    end else if (advance) begin
      s1_valid  <= transfer;
      s1_id     <= win;
      s1_a      <= win_a;
      s1_b      <= win_b;
      rsp_valid <= s1_valid;
      rsp_data  <= gf_mul(s1_a, s1_b);
      rsp_id    <= s1_id;
    end
  end
`else
  // Single output register directly after the multiplier.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_id    <= '0;
    end else if (advance) begin
      rsp_valid <= transfer;
      rsp_data  <= gf_mul(win_a, win_b);
      rsp_id    <= win;
    end
  end
`endif

endmodule

// File: tb/tb_gf_mul_arbiter.sv
// tb_gf_mul_arbiter
// Directed bench for gf_mul_arbiter (NUM_REQ=4). Drivers change inputs 1ns
// after the rising edge; all sampling happens on the falling edge. Expected
// responses {id, data} are queued at grant time and popped by the monitor.
module tb_gf_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
`ifdef GF_MUL_ARB_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                 clk;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [7:0]           rsp_data;
  logic [ID_W-1:0]      rsp_id;

  int total = 0;
  int bad   = 0;
  logic [ID_W+7:0] exp_q[$];

  gf_mul_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b1;
    req_valid = '0;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  // Present mask for one cycle, check the grant, optionally queue the result.
  task automatic grant(input string name, input logic [NUM_REQ-1:0] mask,
                       input logic [NUM_REQ-1:0] exp_rdy, input logic [ID_W-1:0] exp_id,
                       input logic [7:0] exp_d, input bit push);
    req_valid = mask;
    @(negedge clk);
    check(name, 32'(req_ready), 32'(exp_rdy));
    if (push) exp_q.push_back({exp_id, exp_d});
    tick();
    req_valid = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got id=%0d data=0x%02h expected none at %0t",
                 rsp_id, rsp_data, $time);
      end else begin
        logic [ID_W+7:0] e;
        e = exp_q.pop_front();
        if ({rsp_id, rsp_data} !== e) begin
          bad++;
          $display("FAIL rsp: got id=%0d data=0x%02h expected id=%0d data=0x%02h at %0t",
                   rsp_id, rsp_data, e[ID_W+7:8], e[7:0], $time);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    do_reset(3);

    // reset state
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'h00);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    tick();

    // single request with latency check
    set_ops(0, 8'h02, 8'h80);
    grant("single_ready", 4'b0001, 4'b0001, 2'd0, 8'h1D, 1'b1);
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      check("single_lat_early", 32'(rsp_valid), 32'd0);
      tick();
    end
    @(negedge clk);
    check("single_lat_valid", 32'(rsp_valid), 32'd1);
    tick();
    drain();

    // product values
    set_ops(1, 8'h80, 8'h80);
    set_ops(3, 8'h03, 8'h03);
    set_ops(2, 8'hFF, 8'h01);
    set_ops(0, 8'h00, 8'hAB);
    grant("prod_r1", 4'b0010, 4'b0010, 2'd1, 8'h13, 1'b1);
    grant("prod_r3", 4'b1000, 4'b1000, 2'd3, 8'h05, 1'b1);
    grant("prod_r2", 4'b0100, 4'b0100, 2'd2, 8'hFF, 1'b1);
    grant("prod_r0", 4'b0001, 4'b0001, 2'd0, 8'h00, 1'b1);
    drain();

    // round-robin: fresh pointer, all valid for 8 cycles, no gaps
    do_reset(1);
    set_ops(0, 8'h01, 8'h80);
    set_ops(1, 8'h02, 8'h80);
    set_ops(2, 8'h03, 8'h80);
    set_ops(3, 8'h04, 8'h80);
    begin
      logic [7:0] rr_d [4];
      rr_d[0] = 8'h80; rr_d[1] = 8'h1D; rr_d[2] = 8'h9D; rr_d[3] = 8'h3A;
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        check("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
        check("rr_no_gap", 32'(rsp_valid), (k >= LAT) ? 32'd1 : 32'd0);
        exp_q.push_back({ID_W'(k % 4), rr_d[k % 4]});
        tick();
      end
      req_valid = '0;
    end
    drain();

    // backpressure: pointer is at 3, so requester 1 wins next
    rsp_ready = 1'b0;
    set_ops(1, 8'h80, 8'h80);
    set_ops(2, 8'h03, 8'h03);
    set_ops(0, 8'hFF, 8'h01);
    grant("bp_first", 4'b0010, 4'b0010, 2'd1, 8'h13, 1'b1);
    for (int k = 1; k < LAT; k++) tick();
    req_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'h13);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    grant("bp_resume_r2", 4'b0101, 4'b0100, 2'd2, 8'h05, 1'b1);
    grant("bp_resume_r0", 4'b0101, 4'b0001, 2'd0, 8'hFF, 1'b1);
    drain();

    // reset mid-flight: transfer to requester 1, never accepted, then reset
    rsp_ready = 1'b0;
    grant("mid_grant", 4'b0010, 4'b0010, 2'd1, 8'h13, 1'b0);
    do_reset(1);
    rsp_ready = 1'b1;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      check("mid_discard", 32'(rsp_valid), 32'd0);
      tick();
    end
    req_a = '0; req_b = '0;
    set_ops(0, 8'hFF, 8'h01);
    set_ops(1, 8'h80, 8'h80);
    set_ops(2, 8'h03, 8'h03);
    set_ops(3, 8'h00, 8'hAB);
    grant("mid_ptr_reset", 4'b1111, 4'b0001, 2'd0, 8'hFF, 1'b1);
    drain();

    // sparse requests, idle cycles in between must not move the pointer
    grant("sparse_r2", 4'b0100, 4'b0100, 2'd2, 8'h05, 1'b1);
    tick(); tick();
    grant("sparse_r1", 4'b0010, 4'b0010, 2'd1, 8'h13, 1'b1);
    tick();
    grant("sparse_r3", 4'b1001, 4'b1000, 2'd3, 8'h00, 1'b1);
    grant("sparse_r0", 4'b1001, 4'b0001, 2'd0, 8'hFF, 1'b1);
    drain();

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
